// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the two-port memory arbiter
package mem_arbiter_pkg;

    // Arbiter FSM encoding. These three states are the complete state space.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } arb_state_t;

    // Requester identity, used to remember which port was granted last.
    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_id_t;

    // Default number of grant cycles allowed before an unacknowledged access is aborted.
    localparam int DEFAULT_TIMEOUT = 15;

    // Width of the wait counter: enough to reach TIMEOUT-1, never narrower than 4 bits.
    function automatic int timer_width(input int limit);
        int w;
        w = $clog2(limit);
        return (w > 4) ? w : 4;
    endfunction

endpackage

// File: rtl/mem_arbiter_timer.sv
// rtl/mem_arbiter_timer.sv - grant wait counter with terminal-count flag
//
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (held while the arbiter is idle, so every grant starts at 0)
//   en       : count one waiting cycle
//   tc       : high while the current cycle is the LIMIT-th waiting cycle of the grant
module arb_timer
    import mem_arbiter_pkg::*;
#(
    parameter int LIMIT = DEFAULT_TIMEOUT,
    parameter int CNT_W = timer_width(DEFAULT_TIMEOUT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] count;

    // Cycle 1 of a grant sees count=0, so count==LIMIT-1 marks the LIMIT-th cycle.
    assign tc = (count == CNT_W'(LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (instruction/data) arbiter onto a single acked slave
//
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   i_req, i_addr                  : instruction read request and address
//   i_rdata, i_stall               : instruction read data, hold request while high
//   d_req, d_we, d_addr, d_wdata   : data request, write enable, address, write data
//   d_rdata, d_stall               : data read data, hold request while high
//   s_cs, s_we, s_addr, s_wdata    : slave select, write enable, address, write data
//   s_rdata, s_ack                 : slave read data, completion strobe
//   err                            : one-cycle pulse when a grant is aborted by timeout
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [31:0]           i_rdata,
    output logic                  i_stall,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    output logic [31:0]           d_rdata,
    output logic                  d_stall,

    output logic                  s_cs,
    output logic                  s_we,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [31:0]           s_wdata,
    input  logic [31:0]           s_rdata,
    input  logic                  s_ack,

    output logic                  err
);

    localparam int CNT_W = timer_width(TIMEOUT);

    arb_state_t  state;
    port_id_t    last_gnt;
    logic [31:0] i_rdata_q;
    logic [31:0] d_rdata_q;

    logic gnt_i;
    logic gnt_d;
    logic ack_i;
    logic ack_d;
    logic tmo_i;
    logic tmo_d;
    logic tc;

    assign gnt_i = (state == ST_GNT_I);
    assign gnt_d = (state == ST_GNT_D);

    // An ack only completes a transfer while the granted port still requests;
    // a port that has dropped its request is being aborted instead.
    assign ack_i = gnt_i & i_req & s_ack;
    assign ack_d = gnt_d & d_req & s_ack;

    // Timeout fires in the last allowed waiting cycle; an ack in that cycle wins.
    assign tmo_i = gnt_i & i_req & ~s_ack & tc;
    assign tmo_d = gnt_d & d_req & ~s_ack & tc;

    assign err = tmo_i | tmo_d;

    // Stall is released on completion and on timeout so the requester never waits forever.
    assign i_stall = i_req & ~(ack_i | tmo_i);
    assign d_stall = d_req & ~(ack_d | tmo_d);

    // Read data is forwarded straight through on the ack cycle, held thereafter.
    assign i_rdata = ack_i ? s_rdata : i_rdata_q;
    assign d_rdata = ack_d ? s_rdata : d_rdata_q;

    // Every grant is preceded by at least one IDLE cycle, so clearing while idle
    // guarantees the counter starts from zero on grant entry.
    arb_timer #(
        .LIMIT (TIMEOUT),
        .CNT_W (CNT_W)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (state == ST_IDLE),
        .en  (((gnt_i & i_req) | (gnt_d & d_req)) & ~s_ack),
        .tc  (tc)
    );

    // Slave-side mux. Address and write data follow the granted port's live inputs,
    // so an address change mid-grant reaches the slave immediately.
    always_comb begin
        s_cs    = 1'b0;
        s_we    = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        case (state)
            ST_GNT_I: begin
                s_cs   = 1'b1;
                s_addr = i_addr;
            end
            ST_GNT_D: begin
                s_cs    = 1'b1;
                s_we    = d_we;
                s_addr  = d_addr;
                s_wdata = d_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            last_gnt  <= PORT_I;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Under contention grant whichever port was not served last;
                    // s_ack is not looked at here, so a stray ack while idle is harmless.
                    if (d_req && (!i_req || last_gnt == PORT_I)) begin
                        state    <= ST_GNT_D;
                        last_gnt <= PORT_D;
                    end else if (i_req) begin
                        state    <= ST_GNT_I;
                        last_gnt <= PORT_I;
                    end
                end
                ST_GNT_I: begin
                    if (!i_req) begin
                        state <= ST_IDLE;
                    end else if (s_ack) begin
                        i_rdata_q <= s_rdata;
                        state     <= ST_IDLE;
                    end else if (tc) begin
                        state <= ST_IDLE;
                    end
                end
                ST_GNT_D: begin
                    if (!d_req) begin
                        state <= ST_IDLE;
                    end else if (s_ack) begin
                        d_rdata_q <= s_rdata;
                        state     <= ST_IDLE;
                    end else if (tc) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic        s_cs;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [31:0] s_rdata;
    logic        s_ack;
    logic        err;

    int n_checks;
    int n_errors;

    mem_arbiter #(
        .ADDR_WIDTH (32),
        .TIMEOUT    (15)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_stall (i_stall),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_stall (d_stall),
        .s_cs    (s_cs),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata),
        .s_ack   (s_ack),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] arb_exp [4];
        int k;
        int first_err;
        int err_cnt;

        n_checks = 0;
        n_errors = 0;
        rst     = 1'b1;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        s_rdata = '0;
        s_ack   = 1'b0;

        // Reset state
        #3;
        check("rst_s_cs", s_cs, 0);
        check("rst_err", err, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_s_addr", s_addr, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single instruction read, ack after 8 stalled cycles
        next_cycle();
        i_req  = 1'b1;
        i_addr = 32'h4;
        #2;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) begin
                next_cycle();
                #2;
            end
            check("ird_stall_wait", i_stall, 1);
        end
        next_cycle();
        s_ack   = 1'b1;
        s_rdata = 32'h20080005;
        #2;
        check("ird_ack_stall", i_stall, 0);
        check("ird_ack_rdata", i_rdata, 32'h20080005);
        check("ird_s_cs", s_cs, 1);
        check("ird_s_addr", s_addr, 32'h4);
        check("ird_s_we", s_we, 0);
        next_cycle();
        i_req   = 1'b0;
        s_ack   = 1'b0;
        s_rdata = '0;
        #2;
        check("ird_idle_s_cs", s_cs, 0);
        check("ird_held_rdata", i_rdata, 32'h20080005);

        // Ack while idle is ignored
        next_cycle();
        s_ack   = 1'b1;
        s_rdata = 32'h55;
        #2;
        check("idle_ack_i_rdata", i_rdata, 32'h20080005);
        check("idle_ack_d_rdata", d_rdata, 0);
        next_cycle();
        s_ack   = 1'b0;
        s_rdata = '0;
        #2;
        check("idle_ack_s_cs", s_cs, 0);

        // Simultaneous requests from reset: D first, then IDLE, then I
        rst = 1'b1;
        #2;
        rst = 1'b0;
        next_cycle();
        i_req   = 1'b1;
        i_addr  = 32'h8;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h10;
        d_wdata = 32'hDEADBEEF;
        #2;
        check("both_idle_s_cs", s_cs, 0);
        check("both_idle_d_stall", d_stall, 1);
        next_cycle();
        #2;
        check("both_gd_s_cs", s_cs, 1);
        check("both_gd_s_we", s_we, 1);
        check("both_gd_s_addr", s_addr, 32'h10);
        check("both_gd_s_wdata", s_wdata, 32'hDEADBEEF);
        check("both_gd_i_stall", i_stall, 1);
        s_ack   = 1'b1;
        s_rdata = 32'h12345678;
        #1;
        check("both_gd_d_stall", d_stall, 0);
        check("both_gd_d_rdata", d_rdata, 32'h12345678);
        next_cycle();
        d_req = 1'b0;
        d_we  = 1'b0;
        s_ack = 1'b0;
        #2;
        check("both_mid_idle", s_cs, 0);
        next_cycle();
        #2;
        check("both_gi_s_cs", s_cs, 1);
        check("both_gi_s_we", s_we, 0);
        check("both_gi_s_addr", s_addr, 32'h8);
        check("both_gi_s_wdata", s_wdata, 0);
        s_ack   = 1'b1;
        s_rdata = 32'h9ABCDEF0;
        #1;
        check("both_gi_i_rdata", i_rdata, 32'h9ABCDEF0);
        next_cycle();
        i_req = 1'b0;
        s_ack = 1'b0;
        #2;
        check("both_end_s_cs", s_cs, 0);
        check("both_end_d_rdata", d_rdata, 32'h12345678);

        // Continuous contention alternates D,I,D,I
        arb_exp[0] = 32'h200;
        arb_exp[1] = 32'h100;
        arb_exp[2] = 32'h200;
        arb_exp[3] = 32'h100;
        next_cycle();
        i_req  = 1'b1;
        i_addr = 32'h100;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h200;
        #2;
        for (int n = 0; n < 4; n++) begin
            k = 0;
            while (s_cs !== 1'b1 && k < 8) begin
                next_cycle();
                #2;
                k++;
            end
            check("arb_gnt", s_cs, 1);
            check("arb_order", s_addr, arb_exp[n]);
            s_ack   = 1'b1;
            s_rdata = 32'hA0000000 + n;
            #1;
            next_cycle();
            s_ack = 1'b0;
            #2;
        end
        i_req = 1'b0;
        d_req = 1'b0;
        check("arb_d_rdata", d_rdata, 32'hA0000002);
        check("arb_i_rdata", i_rdata, 32'hA0000003);

        // Data port drops its request in cycle 2 of the grant
        next_cycle();
        d_req  = 1'b1;
        d_addr = 32'h30;
        #2;
        check("drop_idle", s_cs, 0);
        next_cycle();
        #2;
        check("drop_gd1_s_cs", s_cs, 1);
        check("drop_gd1_s_addr", s_addr, 32'h30);
        next_cycle();
        d_req   = 1'b0;
        s_rdata = 32'hBADBAD00;
        #2;
        check("drop_gd2_s_cs", s_cs, 1);
        check("drop_gd2_d_stall", d_stall, 0);
        check("drop_gd2_err", err, 0);
        check("drop_gd2_d_rdata", d_rdata, 32'hA0000002);
        next_cycle();
        #2;
        check("drop_after_s_cs", s_cs, 0);
        check("drop_after_err", err, 0);
        check("drop_after_d_rdata", d_rdata, 32'hA0000002);
        s_rdata = '0;

        // Slave never acks: err in grant cycle 15, IDLE next cycle
        next_cycle();
        i_req  = 1'b1;
        i_addr = 32'h40;
        #2;
        first_err = 0;
        err_cnt   = 0;
        for (int g = 1; g <= 15; g++) begin
            next_cycle();
            if (g == 5) i_addr = 32'h44;
            #2;
            if (g == 5) check("tmo_addr_follow", s_addr, 32'h44);
            if (err === 1'b1) begin
                err_cnt++;
                if (first_err == 0) first_err = g;
            end
            if (g == 14) check("tmo_c14_stall", i_stall, 1);
            if (g == 15) begin
                check("tmo_c15_err", err, 1);
                check("tmo_c15_stall", i_stall, 0);
                check("tmo_c15_s_cs", s_cs, 1);
            end
        end
        check("tmo_first_err", first_err, 15);
        check("tmo_err_count", err_cnt, 1);
        next_cycle();
        i_req = 1'b0;
        #2;
        check("tmo_after_s_cs", s_cs, 0);
        check("tmo_after_err", err, 0);
        check("tmo_after_i_rdata", i_rdata, 32'hA0000003);

        // Reset in cycle 3 of an instruction grant
        next_cycle();
        i_req  = 1'b1;
        i_addr = 32'h80;
        #2;
        for (int g = 1; g <= 3; g++) begin
            next_cycle();
            #2;
            check("rstg_s_cs", s_cs, 1);
        end
        rst = 1'b1;
        #1;
        check("rstg_s_cs_drop", s_cs, 0);
        check("rstg_err", err, 0);
        check("rstg_i_rdata", i_rdata, 0);
        check("rstg_d_rdata", d_rdata, 0);
        check("rstg_i_stall", i_stall, 1);
        next_cycle();
        i_req = 1'b0;
        rst   = 1'b0;
        #2;
        check("rstg_after_s_cs", s_cs, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, width of all address ports.
REQ-002 Parameter: TIMEOUT, 15, maximum cycles a grant waits for slave ack before abort.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 i_req  in  1  instruction-port read request.
REQ-006 i_addr  in  ADDR_WIDTH  instruction address.
REQ-007 i_rdata  out  32  instruction read data.
REQ-008 i_stall  out  1  instruction port must hold request.
REQ-009 d_req, d_we  in  1 each  data-port request, write enable.
REQ-010 d_addr  in  ADDR_WIDTH; d_wdata  in  32  data address, write data.
REQ-011 d_rdata  out  32; d_stall  out  1  data read data, data hold.
REQ-012 s_cs, s_we  out  1 each  slave select, write enable.
REQ-013 s_addr  out  ADDR_WIDTH; s_wdata  out  32  slave address, write data.
REQ-014 s_rdata  in  32; s_ack  in  1  slave data, completion strobe.
REQ-015 err  out  1  one-cycle pulse on timeout abort.

Function
REQ-016 FSM states: IDLE, GNT_I, GNT_D; SHALL be the only states.
REQ-017 IDLE: d_req only -> GNT_D; i_req only -> GNT_I; both -> port not granted last (last_gnt register); neither -> IDLE.
REQ-018 last_gnt SHALL update on every entry to GNT_I/GNT_D; reset value = I, so first contention grants D.
REQ-019 In GNT_x, s_cs=1 and s_addr/s_we/s_wdata SHALL be driven from the granted port's current inputs; s_we=0 in GNT_I.
REQ-020 In IDLE, s_cs=0, s_we=0, s_addr=0, s_wdata=0.
REQ-021 GNT_x with s_ack=1 SHALL return to IDLE next cycle; no back-to-back grant without one IDLE cycle.
REQ-022 i_stall = i_req & ~(state==GNT_I & s_ack); d_stall = d_req & ~(state==GNT_D & s_ack); combinational.
REQ-023 i_rdata/d_rdata SHALL be s_rdata combinationally during own ack cycle, else the registered copy captured at that port's last ack.
REQ-024 Granted port dropping its req before s_ack: abort, return to IDLE next cycle, no data capture, no err.
REQ-025 Wait counter (4 bits min) clears on grant entry, increments each GNT_x cycle without s_ack; reaching TIMEOUT -> IDLE, err=1 for one cycle, stall released for that port that cycle.
REQ-026 s_ack in IDLE SHALL be ignored.
REQ-027 Address change on granted port mid-grant SHALL pass through to s_addr unchanged (slave restarts its latency).

Reset
REQ-028 rst=1 forces IDLE, last_gnt=I, counter=0, i_rdata/d_rdata registers=0, err=0 immediately, without clock.
REQ-029 Reset during GNT_x SHALL drop s_cs the same cycle; the interrupted transaction is lost.

Structure
REQ-030 Shared package: FSM state encoding, port-id constants (PORT_I, PORT_D), default TIMEOUT.
REQ-031 One sub-module arb_timer (clear, enable, terminal-count output) is natural; everything else in mem_arbiter.

Verification
REQ-032 i_req, i_addr=0x4, slave acks after 8 cycles with 0x20080005 -> i_stall high 8 cycles, low on ack cycle, i_rdata=0x20080005.
REQ-033 i_req and d_req (d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF) same cycle from reset -> GNT_D first, s_we=1, then IDLE, then GNT_I.
REQ-034 Both requesters held continuously for 4 transactions -> grants alternate D,I,D,I.
REQ-035 Slave never acks, TIMEOUT=15 -> err pulse on cycle 15 of grant, FSM IDLE next cycle.
REQ-036 rst asserted 3 cycles into GNT_I -> s_cs=0 immediately, state IDLE, i_rdata=0.
REQ-037 d_req dropped cycle 2 of GNT_D -> IDLE next cycle, d_rdata unchanged, err=0.
